// File: rtl/icache_line_fetch.sv
// Fetch stage with a direct-mapped, multi-word-line instruction cache.
// Misses refill a whole line one word at a time, forwarding the word the PC is waiting on.
module icache_line_fetch #(
   parameter int ADDR_W     = 32,
   parameter int INDEX_BITS = 6,
   parameter int LINE_LOG2  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc,
   input  logic              flush,
   output logic [ADDR_W-1:0] pc_o,
   output logic [ADDR_W-1:0] inst_o,
   output logic              if_stall,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ok,
   input  logic [ADDR_W-1:0] mem_raddr,
   input  logic [ADDR_W-1:0] mem_rdata,
   output logic [31:0]       hit_cnt,
   output logic [31:0]       miss_cnt
);
   localparam int TAG_W  = ADDR_W - INDEX_BITS - LINE_LOG2 - 2;
   localparam int WIDX_W = INDEX_BITS + LINE_LOG2;
   localparam int NLINES = 1 << INDEX_BITS;
   localparam int NWORDS = 1 << WIDX_W;
   localparam int CNT_W  = (LINE_LOG2 > 0) ? LINE_LOG2 : 1;
   localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'((1 << LINE_LOG2) - 1);
   localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((1 << (LINE_LOG2 + 2)) - 1);

   typedef enum logic {S_IDLE, S_REFILL} state_t;
   state_t r_state, w_state_nxt;

   logic [NLINES-1:0]     r_valid;
   logic [TAG_W-1:0]      r_tag  [NLINES];
   logic [ADDR_W-1:0]     r_data [NWORDS];
   logic [INDEX_BITS-1:0] r_base_idx;
   logic [TAG_W-1:0]      r_base_tag;
   logic [CNT_W-1:0]      r_wcnt;
   logic                  r_flush_pend;
   logic                  r_mem_req;
   logic [ADDR_W-1:0]     r_mem_addr;
   logic [31:0]           r_hit_cnt;
   logic [31:0]           r_miss_cnt;

   logic [INDEX_BITS-1:0] w_idx;
   logic [TAG_W-1:0]      w_tag;
   logic [WIDX_W-1:0]     w_widx;
   logic [WIDX_W-1:0]     w_fill_widx;
   logic                  w_hit, w_fwd, w_miss, w_fill, w_last, w_start;
   logic                  w_unused;

   assign w_idx       = pc[WIDX_W+1:LINE_LOG2+2];
   assign w_tag       = pc[ADDR_W-1:WIDX_W+2];
   assign w_widx      = pc[WIDX_W+1:2];
   // The refill address walks the line, so its index bits name the word being written.
   assign w_fill_widx = r_mem_addr[WIDX_W+1:2];
   assign w_unused    = ^{pc[1:0], mem_raddr[1:0]};

   assign w_hit  = !flush && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
   assign w_fwd  = !flush && !w_hit && mem_ok && (mem_raddr[ADDR_W-1:2] == pc[ADDR_W-1:2]);
   assign w_miss = !flush && !w_hit && !w_fwd;
   assign w_fill = (r_state == S_REFILL) && mem_ok;
   assign w_last = w_fill && (r_wcnt == LAST_WORD);

   always_comb begin
      pc_o     = '0;
      inst_o   = '0;
      if_stall = 1'b0;
      if (!rst) begin
         if (w_hit) begin
            pc_o   = pc;
            inst_o = r_data[w_widx];
         end else if (w_fwd) begin
            pc_o   = pc;
            inst_o = mem_rdata;
         end else begin
            if_stall = 1'b1;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_miss) begin
               w_state_nxt = S_REFILL;
               w_start     = 1'b1;
            end
         end
         S_REFILL: begin
            if (w_last) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_mem_req    <= 1'b0;
         r_mem_addr   <= '0;
         r_wcnt       <= '0;
         r_valid      <= '0;
         r_flush_pend <= 1'b0;
         r_hit_cnt    <= '0;
         r_miss_cnt   <= '0;
         r_base_idx   <= '0;
         r_base_tag   <= '0;
      end else begin
         if (w_hit) r_hit_cnt <= r_hit_cnt + 32'd1;
         if (w_start) begin
            r_mem_req  <= 1'b1;
            r_mem_addr <= pc & LINE_MASK;
            r_base_idx <= w_idx;
            r_base_tag <= w_tag;
            r_wcnt     <= '0;
            r_miss_cnt <= r_miss_cnt + 32'd1;
         end else if (w_fill) begin
            r_mem_addr <= r_mem_addr + ADDR_W'(4);
            r_wcnt     <= r_wcnt + 1'b1;
            if (w_last) r_mem_req <= 1'b0;
         end
         // A flush seen at any point of a refill keeps the finished line invalid.
         if (w_last) begin
            r_flush_pend <= 1'b0;
            if (flush || r_flush_pend) r_valid <= '0;
            else                       r_valid[r_base_idx] <= 1'b1;
         end else if (flush) begin
            if (r_state == S_IDLE) r_valid <= '0;
            else                   r_flush_pend <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && w_fill) r_data[w_fill_widx] <= mem_rdata;
      if (!rst && w_last) r_tag[r_base_idx] <= r_base_tag;
   end

   assign mem_req  = r_mem_req;
   assign mem_addr = r_mem_addr;
   assign hit_cnt  = r_hit_cnt;
   assign miss_cnt = r_miss_cnt;
endmodule

// File: doc/icache_line_fetch.md
Name: icache_line_fetch

Overview:
- Parametrised instruction-fetch stage with a direct-mapped, multi-word-line I-cache. Successor to the single-word-line fetch stage.
- Adds configurable index depth and line size, a sequential line-refill FSM, critical-word forwarding, hit-under-refill, and a flush (fence.i) with valid-bit clearing.
- Sits between the PC register and the ID stage. Issues word fetches to the memory controller and reports a stall to the pipeline controller.

Parameters:
ADDR_W, 32, address and instruction width in bits.
INDEX_BITS, 6, log2 of the number of cache lines (64 lines).
LINE_LOG2, 2, log2 of words per line (4 words = 16 B). Must be >= 0.
TAG_W = ADDR_W-INDEX_BITS-LINE_LOG2-2 is derived and is not an override.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
pc  in  ADDR_W  fetch PC; bits [1:0] ignored
flush  in  1  invalidate whole cache (fence.i), one-cycle pulse
pc_o  out  ADDR_W  PC of delivered instruction
inst_o  out  ADDR_W  delivered instruction
if_stall  out  1  1 = no instruction delivered this cycle
mem_req  out  1  word fetch request
mem_addr  out  ADDR_W  word-aligned fetch address
mem_ok  in  1  one-cycle pulse: mem_rdata valid for mem_raddr
mem_raddr  in  ADDR_W  address of returned word
mem_rdata  in  ADDR_W  returned word
hit_cnt  out  32  lookups that hit (wraps)
miss_cnt  out  32  line refills started (wraps)

Behaviour:
- Address split: offset=pc[LINE_LOG2+1:2], index=next INDEX_BITS bits, tag=top TAG_W bits.
- Storage: valid[2^INDEX_BITS], tag array, data array of 2^(INDEX_BITS+LINE_LOG2) words.
- Reset: all valid bits cleared, state IDLE, mem_req=0, mem_addr=0, counters=0, flush_pend=0. Outputs pc_o, inst_o, if_stall are combinational. While rst=1 they read 0, 0, 0.
- Lookup (combinational, 0-cycle):
  - Hit = valid & tag match. On hit: inst_o=data[index,offset], pc_o=pc, if_stall=0.
  - Otherwise, if mem_ok & mem_raddr[ADDR_W-1:2]==pc[ADDR_W-1:2] (forwarding): inst_o=mem_rdata, pc_o=pc, if_stall=0.
  - Otherwise: if_stall=1, inst_o=0, pc_o=0.
  - In a cycle with flush=1 every lookup misses.
- FSM IDLE:
  - On a miss (not forwarded, no flush): latch line base = pc with offset and [1:0] zeroed. Go to REFILL next edge. Raise mem_req with mem_addr=line base. miss_cnt+1.
- FSM REFILL:
  - mem_req stays 1. mem_addr is held stable until mem_ok.
  - On each mem_ok: write mem_rdata into data[base index, word counter]. Advance mem_addr by 4 and increment the word counter.
  - On the mem_ok for the last word (counter = 2^LINE_LOG2-1), at the same edge: mem_req=0, go to IDLE, write tag, and set valid=1 unless flush_pend or flush. The line becomes hittable on the following cycle.
  - Words are fetched in ascending order from offset 0. There is no wrap-around and no critical-word-first.
- PC changes during REFILL: the refill always runs to completion and is never aborted.
  - Hit-under-refill: lookups to other valid lines still hit.
  - A miss to a different line stalls until the next return to IDLE, then starts its own refill.
  - A miss to the line being filled is served only by forwarding or after completion.
- Flush in IDLE: all valid bits cleared at that edge. A pending miss is ignored that cycle. Refill starts on the next cycle if still missing.
- Flush in REFILL: set flush_pend. At refill completion the line is written but valid stays 0, all valid bits clear, and flush_pend clears.
- Counters: hit_cnt increments each cycle with rst=0, flush=0 and hit=1. Each refill start increments miss_cnt by 1 (stalled cycles are not counted). Both counters wrap at 2^32 with no saturation.
- Reset mid-REFILL: state returns to IDLE and mem_req drops at that edge. Data arrays are not cleared.

Test Plan:
- Cold miss: rst 2 cycles, pc=0x1000, mem_ok returns 0xA0..0xA3 for 0x1000..0x100C, one per 2 cycles. Required: mem_addr steps 0x1000/4/8/C; stall=0 with inst_o=0xA0 in the 0x1000 mem_ok cycle; miss_cnt=1; pc=0x1008 next cycle after completion gives inst_o=0xA2, stall=0, hit_cnt=1.
- Conflict eviction: after the line for 0x1000 is filled, pc=0x1400 (same index 0, tag 5). Required: new refill with miss_cnt=2; afterwards pc=0x1000 misses again.
- Hit-under-refill: line 0x2000 valid, refill of 0x3000 in progress, pc=0x2004. Required: stall=0, inst_o=cached word, mem_req stays 1, mem_addr unchanged.
- Flush in IDLE: lines 0x1000 and 0x2000 valid, flush pulse. Required: that cycle stall=1; next cycle pc=0x1000 misses and starts a refill.
- Flush mid-refill: flush at 2nd word of 0x1000 refill. Required: refill completes all 4 words; afterwards pc=0x1000 and a prior-valid 0x2000 both miss.
- Parameter sweep: LINE_LOG2=0, INDEX_BITS=3. Required: one mem_ok per refill, pc=0x20 and 0x00 conflict, counters match the scoreboard.
